game_ctrl_fsm: RTL

Parametrised controller for the cellular game array. It sequences board load, restart, iteration (read, then write-out), pause, win and lose. It replaces the fixed-constant two-phase controller with a single-clock design, and adds the following: generic cycle counts, a true per-generation counter, an explicit lose flag, single-step mode, abort-on-restart and an iteration-done strobe. It sits between the user input/debounce logic and the array read/write datapath.

---
 rtl/game_ctrl_fsm_if.sv | 29 ++
 rtl/game_ctrl_fsm.sv | 120 ++++++++++++
 2 files changed

// File: rtl/game_ctrl_fsm_if.sv
// Handshake bundle between the user/debounce side (master) and the game controller (slave).
interface game_ctrl_fsm_if #(
    parameter int GEN_W = 9
);
    logic             inp;
    logic             run;
    logic             step;
    logic             wai;
    logic             lose_sig;
    logic [2:0]       state;
    logic [GEN_W-1:0] count;
    logic             load_data;
    logic             read_data;
    logic             writeout;
    logic             restart;
    logic             win;
    logic             lose;
    logic             iter_done;

    modport master (
        output inp, run, step, wai, lose_sig,
        input  state, count, load_data, read_data, writeout, restart, win, lose, iter_done
    );

    modport slave (
        input  inp, run, step, wai, lose_sig,
        output state, count, load_data, read_data, writeout, restart, win, lose, iter_done
    );
endinterface

// File: rtl/game_ctrl_fsm.sv
// Cellular game array controller: load, restart, read/write-out iterations, pause, win/lose.
// Strobes are registered from the next-state decode so they line up exactly with the state register.
module game_ctrl_fsm #(
    parameter int GEN_W        = 9,
    parameter int CYC_W        = 4,
    parameter int READ_CYCLES  = 4,
    parameter int WRITE_CYCLES = 1,
    parameter int LOAD_CYCLES  = 1,
    parameter int WIN_GENS     = 3
) (
    input logic             clka,
    input logic             rst_n,
    game_ctrl_fsm_if.slave  gc
);

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        WIN      = 3'b001,
        INPUT    = 3'b010,
        READ     = 3'b011,
        WRITEOUT = 3'b100,
        WAIT     = 3'b101,
        LOSE     = 3'b110,
        RESTART  = 3'b111
    } state_t;

    localparam logic [CYC_W-1:0] RD_LAST  = CYC_W'(READ_CYCLES - 1);
    localparam logic [CYC_W-1:0] WR_LAST  = CYC_W'(WRITE_CYCLES - 1);
    localparam logic [CYC_W-1:0] LD_LAST  = CYC_W'(LOAD_CYCLES - 1);
    localparam logic [GEN_W-1:0] WIN_CNT  = GEN_W'(WIN_GENS);

    state_t           st, st_nxt;
    logic [CYC_W-1:0] cyc, cyc_nxt;
    logic [GEN_W-1:0] cnt, cnt_nxt;
    logic             load_q, read_q, wr_q, rst_q, win_q, lose_q, iter_q;

    function automatic logic [GEN_W-1:0] sat_inc(input logic [GEN_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        st_nxt  = st;
        cnt_nxt = cnt;
        case (st)
            IDLE: begin
                if (gc.inp)                    st_nxt = RESTART;
                else if (gc.run || gc.step) begin
                    if (gc.lose_sig)           st_nxt = LOSE;
                    else if (cnt == WIN_CNT)   st_nxt = WIN;
                    else if (gc.wai)           st_nxt = WAIT;
                    else                       st_nxt = READ;
                end
            end
            READ: begin
                if (gc.inp)                    st_nxt = RESTART;
                else if (cyc == RD_LAST)       st_nxt = WRITEOUT;
            end
            WRITEOUT: begin
                if (cyc == WR_LAST) begin
                    st_nxt  = IDLE;
                    cnt_nxt = sat_inc(cnt);
                end
            end
            WAIT: begin
                if (gc.lose_sig)               st_nxt = LOSE;
                else if (gc.inp)               st_nxt = RESTART;
                else if (!gc.wai)              st_nxt = IDLE;
            end
            WIN, LOSE: begin
                if (gc.inp)                    st_nxt = RESTART;
            end
            RESTART: begin
                st_nxt  = INPUT;
                cnt_nxt = '0;
            end
            INPUT: begin
                if (cyc == LD_LAST)            st_nxt = IDLE;
            end
            default:                           st_nxt = IDLE;
        endcase
        cyc_nxt = (st_nxt != st) ? '0 : cyc + 1'b1;
    end

    always_ff @(posedge clka) begin
        if (!rst_n) begin
            st     <= IDLE;
            cyc    <= '0;
            cnt    <= '0;
            load_q <= 1'b0;
            read_q <= 1'b0;
            wr_q   <= 1'b0;
            rst_q  <= 1'b0;
            win_q  <= 1'b0;
            lose_q <= 1'b0;
            iter_q <= 1'b0;
        end else begin
            st     <= st_nxt;
            cyc    <= cyc_nxt;
            cnt    <= cnt_nxt;
            load_q <= (st_nxt == INPUT);
            read_q <= (st_nxt == READ);
            wr_q   <= (st_nxt == WRITEOUT);
            rst_q  <= (st_nxt == RESTART);
            win_q  <= (st_nxt == WIN);
            lose_q <= (st_nxt == LOSE);
            iter_q <= (st_nxt == WRITEOUT) && (cyc_nxt == WR_LAST);
        end
    end

    assign gc.state     = st;
    assign gc.count     = cnt;
    assign gc.load_data = load_q;
    assign gc.read_data = read_q;
    assign gc.writeout  = wr_q;
    assign gc.restart   = rst_q;
    assign gc.win       = win_q;
    assign gc.lose      = lose_q;
    assign gc.iter_done = iter_q;

endmodule
